// File: rtl/modadder_ctrl.sv
// Sequences two mpadder operations per request into a modular add/subtract; constant latency per request.
// Optional MODADD_BUSY_ERR_EN adds a sticky err flag for start pulses that arrive while busy or in FIN.
module modadder_ctrl #(
    parameter int WIDTH = 1027
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
`ifdef MODADD_BUSY_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             sub_q, sub_d;
    logic             s1_q, s1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             add_start_q, add_start_d;
    logic             add_subtract_q, add_subtract_d;
    logic [WIDTH-1:0] add_in_a_q, add_in_a_d;
    logic [WIDTH-1:0] add_in_b_q, add_in_b_d;
    logic             err_q, err_d;

    always_comb begin
        state_d        = state_q;
        mod_d          = mod_q;
        sub_d          = sub_q;
        s1_d           = s1_q;
        result_d       = result_q;
        done_d         = done_q;
        busy_d         = busy_q;
        add_start_d    = add_start_q;
        add_subtract_d = add_subtract_q;
        add_in_a_d     = add_in_a_q;
        add_in_b_d     = add_in_b_q;
        err_d          = err_q | (start & (busy_q | (state_q == FIN)));

        case (state_q)
            IDLE: begin
                if (start) begin
                    mod_d          = modulus;
                    sub_d          = subtract;
                    add_in_a_d     = in_a;
                    add_in_b_d     = in_b;
                    add_subtract_d = subtract;
                    add_start_d    = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = REQ1;
                end
            end
            REQ1: begin
                // add_done may be stale from the previous operation, so it is not looked at here
                add_start_d = 1'b0;
                state_d     = WAIT1;
            end
            WAIT1: begin
                if (add_done) begin
                    // r1 lives on in add_in_a for the rest of the request
                    s1_d           = add_result[WIDTH];
                    add_in_a_d     = add_result[WIDTH-1:0];
                    add_in_b_d     = mod_q;
                    add_subtract_d = ~sub_q;
                    add_start_d    = 1'b1;
                    state_d        = REQ2;
                end
            end
            REQ2: begin
                add_start_d = 1'b0;
                state_d     = WAIT2;
            end
            WAIT2: begin
                if (add_done) begin
                    if (sub_q) begin
                        result_d = s1_q ? add_result[WIDTH-1:0] : add_in_a_q;
                    end else begin
                        result_d = add_result[WIDTH] ? add_in_a_q : add_result[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            mod_q          <= '0;
            sub_q          <= 1'b0;
            s1_q           <= 1'b0;
            result_q       <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            add_start_q    <= 1'b0;
            add_subtract_q <= 1'b0;
            add_in_a_q     <= '0;
            add_in_b_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mod_q          <= mod_d;
            sub_q          <= sub_d;
            s1_q           <= s1_d;
            result_q       <= result_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            add_start_q    <= add_start_d;
            add_subtract_q <= add_subtract_d;
            add_in_a_q     <= add_in_a_d;
            add_in_b_q     <= add_in_b_d;
            err_q          <= err_d;
        end
    end

    assign result       = result_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign add_start    = add_start_q;
    assign add_subtract = add_subtract_q;
    assign add_in_a     = add_in_a_q;
    assign add_in_b     = add_in_b_q;

`ifdef MODADD_BUSY_ERR_EN
    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_modadder_ctrl.sv
// Bench for modadder_ctrl with a behavioural mpadder in the loop and a modular-arithmetic reference.
module tb_modadder_ctrl;
    localparam int WIDTH = 1027;
    localparam int W1    = WIDTH + 1;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a, in_b, modulus;
    logic [WIDTH-1:0] result;
    logic             done, busy, add_start, add_subtract;
    logic [WIDTH-1:0] add_in_a, add_in_b;
    logic [WIDTH:0]   add_result;
    logic             add_done;
`ifdef MODADD_BUSY_ERR_EN
    logic             err;
`endif

    modadder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .modulus(modulus),
        .result(result), .done(done), .busy(busy),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_result(add_result), .add_done(add_done)
`ifdef MODADD_BUSY_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // mpadder stand-in: result after LAT cycles, done stays high until the next start
    int             mp_cnt;
    logic           mp_done;
    logic [WIDTH:0] mp_res;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mp_cnt  <= 0;
            mp_done <= 1'b0;
            mp_res  <= '0;
        end else if (add_start) begin
            mp_cnt  <= LAT;
            mp_done <= 1'b0;
            mp_res  <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                    : ({1'b0, add_in_a} + {1'b0, add_in_b});
        end else if (mp_cnt != 0) begin
            mp_cnt <= mp_cnt - 1;
            if (mp_cnt == 1) mp_done <= 1'b1;
        end
    end
    assign add_done   = mp_done;
    assign add_result = mp_res;

    int n_chk  = 0;
    int n_fail = 0;
    int lat_ref = 0;
    int as_cnt = 0;
    logic [WIDTH-1:0] expq[$];
    logic [WIDTH-1:0] last_res = '0;

    task automatic chk(input string nm, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (low 128 bits)", nm, act[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input bit sub, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] t;
        if (!sub) t = ({2'b0, a} + {2'b0, b}) % {2'b0, m};
        else      t = ({2'b0, a} + {2'b0, m} - {2'b0, b}) % {2'b0, m};
        return t[WIDTH-1:0];
    endfunction

    // Per-cycle checker: each done pops one expectation, result must hold otherwise
    always @(negedge clk) begin
        if (!resetn) begin
            as_cnt   = 0;
            last_res = '0;
        end else begin
            if (add_start) as_cnt++;
            if (done) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done: done=1, required no done");
                end else begin
                    last_res = expq.pop_front();
                    chk("result", W1'(result), W1'(last_res));
                end
                chk("add_start_pulses", W1'(as_cnt), W1'(2));
                chk("busy_at_done", W1'(busy), W1'(0));
                as_cnt = 0;
            end else begin
                chk("result_held", W1'(result), W1'(last_res));
            end
        end
    end

    task automatic do_op(input bit sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp_lit,
                         input int dup_at, input bit fin_poke, input string nm);
        int lat;
        lat = 0;
        @(negedge clk);
        chk({nm, "_model"}, W1'(model(sub, a, b, m)), W1'(exp_lit));
        expq.push_back(exp_lit);
        subtract = sub; in_a = a; in_b = b; modulus = m; start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start    = (k == dup_at);
            in_a     = 1;
            in_b     = 2;
            modulus  = 7;
            subtract = ~sub;
            if (k == 1) chk({nm, "_busy_after_start"}, W1'(busy), W1'(1));
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        if (lat == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: done=0 after 200 cycles, required done=1", nm);
        end else if (lat_ref == 0) begin
            lat_ref = lat;
        end else begin
            chk({nm, "_latency"}, W1'(lat), W1'(lat_ref));
        end
        if (fin_poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({nm, "_fin_start_ignored"}, W1'(busy), W1'(0));
            @(negedge clk);
            chk({nm, "_idle_after_fin"}, W1'(busy), W1'(0));
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_done"}, W1'(done), W1'(0));
        chk({nm, "_busy"}, W1'(busy), W1'(0));
        chk({nm, "_add_start"}, W1'(add_start), W1'(0));
        chk({nm, "_add_subtract"}, W1'(add_subtract), W1'(0));
        chk({nm, "_result"}, W1'(result), W1'(0));
        chk({nm, "_add_in_a"}, W1'(add_in_a), W1'(0));
        chk({nm, "_add_in_b"}, W1'(add_in_b), W1'(0));
`ifdef MODADD_BUSY_ERR_EN
        chk({nm, "_err"}, W1'(err), W1'(0));
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] big_m;
        bit               seen;
        resetn = 1'b0; start = 1'b0; subtract = 1'b0;
        in_a = '0; in_b = '0; modulus = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;

        do_op(1'b0, 5, 7, 13, 12, 0, 1'b0, "add_5_7");
        do_op(1'b0, 9, 8, 13, 4, 0, 1'b0, "add_9_8");
        do_op(1'b0, 6, 7, 13, 0, 0, 1'b0, "add_6_7");
        do_op(1'b1, 8, 3, 13, 5, 0, 1'b0, "sub_8_3");
        do_op(1'b1, 3, 8, 13, 8, 0, 1'b0, "sub_3_8");
        do_op(1'b1, 4, 4, 13, 0, 0, 1'b0, "sub_4_4");

        big_m = (WIDTH'(1) << 1024) - WIDTH'(105);
        do_op(1'b0, big_m - 1, big_m - 1, big_m, big_m - 2, 0, 1'b0, "big_add");
        do_op(1'b1, big_m - 1, big_m - 1, big_m, 0, 0, 1'b0, "big_sub");

`ifdef MODADD_BUSY_ERR_EN
        chk("err_before_dup", W1'(err), W1'(0));
`endif
        do_op(1'b0, 5, 7, 13, 12, 3, 1'b1, "dup_start");
`ifdef MODADD_BUSY_ERR_EN
        chk("err_after_dup", W1'(err), W1'(1));
`endif
        do_op(1'b1, 8, 3, 13, 5, 0, 1'b0, "after_dup");
`ifdef MODADD_BUSY_ERR_EN
        chk("err_sticky", W1'(err), W1'(1));
`endif

        // Abort in WAIT1: no done may follow, the next request must still be correct
        @(negedge clk);
        subtract = 1'b0; in_a = 9; in_b = 3; modulus = 13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (add_start) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_saw_add_start", W1'(seen), W1'(1));
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        do_op(1'b0, 2, 5, 13, 7, 0, 1'b0, "add_2_5");
        repeat (4) @(negedge clk);
        chk("queue_drained", W1'(expq.size()), W1'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
